reflet_gpio_irq: RTL and testbench
==================================

REFLET_GPIO_IRQ -- requirements
Module: reflet_gpio_irq

Interface
REQ-001 SHALL have parameter wordsize, default 8, bus data width.
REQ-002 SHALL have parameter base_addr_size, default 16, width of addr.
REQ-003 SHALL have parameter base_addr, default 0, first address of the register window.
REQ-004 SHALL have parameter nb_pins, default 16, pin count (1..64); S = ceil(nb_pins/wordsize) slices per register.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 enable  in  1  module select from address decode.
REQ-008 addr  in  base_addr_size  bus address.
REQ-009 write_en  in  1  write strobe.
REQ-010 data_in  in  wordsize  write data.
REQ-011 data_out  out  wordsize  read data; all-zero when not selected (OR-combined bus).
REQ-012 gpi  in  nb_pins  asynchronous general-purpose inputs.
REQ-013 gpo  out  nb_pins  general-purpose outputs.
REQ-014 interrupt  out  1  level interrupt request to interrupt mux.

Function
REQ-015 SHALL decode offset = addr - base_addr; selected when enable=1 and offset < 6*S+1.
REQ-016 Register blocks SHALL be at offset blk*S+slice: blk0 GPI (RO), blk1 GPO (RW), blk2 RISE_EN (RW), blk3 FALL_EN (RW), blk4 PENDING (R, write-1-to-clear), blk5 LEVEL_EN (RW); offset 6*S is CTRL (bit0 global interrupt enable, other bits read 0).
REQ-017 Slice k SHALL map pins [k*wordsize +: wordsize]; bits beyond nb_pins SHALL read 0 and ignore writes.
REQ-018 Reads SHALL be combinational (same cycle as addr); writes SHALL take effect on the clk edge with enable=1 and write_en=1.
REQ-019 gpi SHALL pass a 2-flop synchroniser; edge detect compares synchronised value with its 1-cycle delayed copy.
REQ-020 PENDING[i] SHALL set on rising edge with RISE_EN[i], falling edge with FALL_EN[i], or every cycle the synchronised pin is high with LEVEL_EN[i].
REQ-021 Simultaneous set and write-1-clear on one bit SHALL leave the bit set.
REQ-022 interrupt SHALL be registered: CTRL[0] & |PENDING, one cycle after PENDING.
REQ-023 Latency without debounce: gpi change to PENDING = 3 rising edges; to interrupt = 4.
REQ-024 Unselected accesses, and writes to GPI, SHALL have no effect.

Reset
REQ-025 On reset low all registers, synchroniser and delay flops, gpo, PENDING and interrupt SHALL be 0 immediately, independent of clk.
REQ-026 Pins high at reset release MAY produce a rising edge; SHALL not set PENDING since RISE_EN resets to 0.
REQ-027 Reset mid-transaction SHALL discard the write.

Configuration
REQ-028 Macro REFLET_GPIO_IRQ_DEBOUNCE_EN: when defined, each synchronised pin SHALL feed a filter accepting a new value only after 4 consecutive equal samples (latency +3 cycles); when undefined, the filter SHALL be absent and REQ-023 holds.

Structure
REQ-029 Register block indices and CTRL bit positions SHALL be constants in shared package reflet_gpio_irq_pkg.
REQ-030 The per-pin synchroniser/debounce/edge-detect SHALL be sub-module reflet_gpio_irq_pin, instantiated nb_pins times.

Verification (wordsize 8, nb_pins 16, base_addr 0x00, no debounce unless stated)
REQ-031 Write 0xA5 to offset 2, 0x3C to offset 3 -> gpo = 16'h3CA5; reads return same.
REQ-032 RISE_EN=0x0001, CTRL=1, gpi 0->16'h0001 -> PENDING slice0 = 0x01 after 3 edges, interrupt=1 after 4; write 0x01 to offset 8 -> interrupt=0 one cycle later.
REQ-033 FALL_EN slice1=0x80, gpi 16'h8000->0 -> PENDING offset 9 = 0x80; CTRL=0 keeps interrupt=0.
REQ-034 LEVEL_EN=0x0002, gpi=16'h0002 held, clear PENDING same cycle as set -> bit stays 1.
REQ-035 Assert reset with gpo=16'hFFFF and interrupt=1 -> both 0 before next clk edge.
REQ-036 With REFLET_GPIO_IRQ_DEBOUNCE_EN, 2-cycle pulse on gpi[0] with RISE_EN=1 -> PENDING stays 0; 6-cycle pulse -> PENDING set at edge 6.

Source files
------------

// File: rtl/reflet_gpio_irq_pkg.sv
// Shared constants for the reflet_gpio_irq register map.
// Register window layout: block index * S + slice, with CTRL after the last block.
package reflet_gpio_irq_pkg;

    // Register block indices
    localparam int unsigned BLK_GPI   = 0;
    localparam int unsigned BLK_GPO   = 1;
    localparam int unsigned BLK_RISE  = 2;
    localparam int unsigned BLK_FALL  = 3;
    localparam int unsigned BLK_PEND  = 4;
    localparam int unsigned BLK_LEVEL = 5;
    localparam int unsigned NB_BLK    = 6;

    // CTRL register bit positions
    localparam int unsigned CTRL_IE_BIT = 0;

    // Number of bus-word slices needed to cover all pins
    function automatic int unsigned slices(input int unsigned pins, input int unsigned ws);
        return (pins + ws - 1) / ws;
    endfunction

endpackage

// File: rtl/reflet_gpio_irq_pin.sv
// Per-pin input path: 2-flop synchroniser, optional debounce filter, edge detect.
// Build option: define REFLET_GPIO_IRQ_DEBOUNCE_EN to insert the 4-sample debounce filter.
module reflet_gpio_irq_pin (
    input  logic clk,
    input  logic reset,
    input  logic gpi,
    output logic level,
    output logic rise,
    output logic fall
);
    logic sync1;
    logic sync2;
    logic prev;

    // Two-flop synchroniser for the asynchronous pin
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= gpi;
            sync2 <= sync1;
        end
    end

`ifdef REFLET_GPIO_IRQ_DEBOUNCE_EN
    logic [2:0] hist;

    // Keep the three previous synchronised samples (hist[0] newest)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) hist <= '0;
        else        hist <= {hist[1:0], sync2};
    end

    // Accept the synchronised value once it matches the last three samples,
    // otherwise hold the previously accepted value (prev)
    always_comb begin
        level = (hist == {3{sync2}}) ? sync2 : prev;
    end
`else
    // Without the filter the synchronised value is used directly
    always_comb begin
        level = sync2;
    end
`endif

    // One-cycle delayed copy of the accepted level for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) prev <= 1'b0;
        else        prev <= level;
    end

    // Edge detection against the delayed copy
    always_comb begin
        rise = level & ~prev;
        fall = ~level & prev;
    end

endmodule

// File: rtl/reflet_gpio_irq.sv
// GPIO block with per-pin rise/fall/level interrupt sources and a bus register window.
// Build option: define REFLET_GPIO_IRQ_DEBOUNCE_EN to add a debounce filter on every pin.
module reflet_gpio_irq
    import reflet_gpio_irq_pkg::*;
#(
    parameter int unsigned                wordsize       = 8,
    parameter int unsigned                base_addr_size = 16,
    parameter logic [base_addr_size-1:0]  base_addr      = '0,
    parameter int unsigned                nb_pins        = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [base_addr_size-1:0] addr,
    input  logic                      write_en,
    input  logic [wordsize-1:0]       data_in,
    output logic [wordsize-1:0]       data_out,
    input  logic [nb_pins-1:0]        gpi,
    output logic [nb_pins-1:0]        gpo,
    output logic                      interrupt
);
    localparam int unsigned S   = slices(nb_pins, wordsize);
    localparam int unsigned WIN = NB_BLK * S + 1;

    logic [base_addr_size-1:0]     offset;
    logic                          sel;
    logic                          wr;
    logic [nb_pins-1:0]            level, rise, fall;
    logic [nb_pins-1:0]            rise_en, fall_en, level_en, pending;
    logic [nb_pins-1:0]            wbit, w_gpo, w_rise, w_fall, w_level, w_pend;
    logic [nb_pins-1:0]            set_ev;
    logic                          w_ie;
    logic                          ie;
    logic [NB_BLK-1:0][nb_pins-1:0] regs;

    // Per-pin synchroniser / filter / edge detector
    for (genvar g = 0; g < nb_pins; g++) begin : g_pin
        reflet_gpio_irq_pin u_pin (
            .clk   (clk),
            .reset (reset),
            .gpi   (gpi[g]),
            .level (level[g]),
            .rise  (rise[g]),
            .fall  (fall[g])
        );
    end

    // Address decode and per-pin write strobes (pin i lives in slice i/wordsize)
    always_comb begin
        offset  = addr - base_addr;
        sel     = enable && (offset < base_addr_size'(WIN));
        wr      = sel && write_en;
        wbit    = '0;
        w_gpo   = '0;
        w_rise  = '0;
        w_fall  = '0;
        w_level = '0;
        w_pend  = '0;
        for (int unsigned i = 0; i < nb_pins; i++) begin
            wbit[i]    = data_in[i % wordsize];
            w_gpo[i]   = wr && (offset == base_addr_size'(BLK_GPO   * S + i / wordsize));
            w_rise[i]  = wr && (offset == base_addr_size'(BLK_RISE  * S + i / wordsize));
            w_fall[i]  = wr && (offset == base_addr_size'(BLK_FALL  * S + i / wordsize));
            w_level[i] = wr && (offset == base_addr_size'(BLK_LEVEL * S + i / wordsize));
            w_pend[i]  = wr && (offset == base_addr_size'(BLK_PEND  * S + i / wordsize));
        end
        w_ie = wr && (offset == base_addr_size'(NB_BLK * S));
    end

    // Interrupt sources for this cycle
    always_comb begin
        set_ev = (rise_en & rise) | (fall_en & fall) | (level_en & level);
    end

    // Register file; a new event wins over a write-1-to-clear on the same bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpo       <= '0;
            rise_en   <= '0;
            fall_en   <= '0;
            level_en  <= '0;
            pending   <= '0;
            ie        <= 1'b0;
            interrupt <= 1'b0;
        end else begin
            gpo       <= (gpo      & ~w_gpo)   | (wbit & w_gpo);
            rise_en   <= (rise_en  & ~w_rise)  | (wbit & w_rise);
            fall_en   <= (fall_en  & ~w_fall)  | (wbit & w_fall);
            level_en  <= (level_en & ~w_level) | (wbit & w_level);
            pending   <= (pending  & ~(w_pend & wbit)) | set_ev;
            if (w_ie) ie <= data_in[CTRL_IE_BIT];
            interrupt <= ie & (|pending);
        end
    end

    // Readable views of each block
    always_comb begin
        regs            = '0;
        regs[BLK_GPI]   = level;
        regs[BLK_GPO]   = gpo;
        regs[BLK_RISE]  = rise_en;
        regs[BLK_FALL]  = fall_en;
        regs[BLK_PEND]  = pending;
        regs[BLK_LEVEL] = level_en;
    end

    // Combinational read mux; zero when not selected so the bus can be OR-combined
    always_comb begin
        data_out = '0;
        if (sel) begin
            for (int unsigned b = 0; b < NB_BLK; b++) begin
                for (int unsigned i = 0; i < nb_pins; i++) begin
                    if (offset == base_addr_size'(b * S + i / wordsize))
                        data_out[i % wordsize] = regs[b][i];
                end
            end
            if (offset == base_addr_size'(NB_BLK * S))
                data_out[CTRL_IE_BIT] = ie;
        end
    end

endmodule

// File: tb/tb_reflet_gpio_irq.sv
// Self-checking bench for reflet_gpio_irq (wordsize 8, nb_pins 16, base_addr 0).
module tb_reflet_gpio_irq;
    localparam int W = 8;
    localparam int N = 16;
    localparam int S = 2;
`ifdef REFLET_GPIO_IRQ_DEBOUNCE_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        write_en = 1'b0;
    logic [15:0] addr = '0;
    logic [7:0]  data_in = '0;
    logic [7:0]  data_out;
    logic [15:0] gpi = '0;
    logic [15:0] gpo;
    logic        interrupt;

    int n_cmp = 0;
    int n_bad = 0;
    bit done = 1'b0;

    always #5 clk = ~clk;

    reflet_gpio_irq #(
        .wordsize       (8),
        .base_addr_size (16),
        .base_addr      (16'h0000),
        .nb_pins        (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .addr      (addr),
        .write_en  (write_en),
        .data_in   (data_in),
        .data_out  (data_out),
        .gpi       (gpi),
        .gpo       (gpo),
        .interrupt (interrupt)
    );

    // Reference model: register contents plus a history of gpi samples
    logic [15:0] m_gpo, m_rise, m_fall, m_lvl_en, m_pend, m_filt;
    logic        m_ie, m_irq;
    logic [15:0] smp [0:4];   // smp[k] = gpi sampled k edges ago

    task automatic model_reset();
        m_gpo = '0; m_rise = '0; m_fall = '0; m_lvl_en = '0; m_pend = '0;
        m_filt = '0; m_ie = 1'b0; m_irq = 1'b0;
        for (int k = 0; k < 5; k++) smp[k] = '0;
    endtask

    // Pin value as seen by the interrupt logic (two samples of synchronisation,
    // optionally requiring four equal consecutive samples)
    function automatic logic [15:0] m_level();
        logic [15:0] v;
`ifdef REFLET_GPIO_IRQ_DEBOUNCE_EN
        for (int i = 0; i < N; i++)
            v[i] = (smp[1][i] == smp[2][i] && smp[2][i] == smp[3][i] && smp[3][i] == smp[4][i])
                   ? smp[1][i] : m_filt[i];
`else
        v = smp[1];
`endif
        return v;
    endfunction

    function automatic logic [7:0] m_read(input logic en, input logic [15:0] a);
        logic [15:0] r;
        int off;
        off = int'(a);
        if (!en || off >= 6 * S + 1) return 8'h00;
        if (off == 6 * S) return {7'b0, m_ie};
        case (off / S)
            0:       r = m_level();
            1:       r = m_gpo;
            2:       r = m_rise;
            3:       r = m_fall;
            4:       r = m_pend;
            default: r = m_lvl_en;
        endcase
        r = r >> ((off % S) * W);
        return r[7:0];
    endfunction

    task automatic model_step();
        logic [15:0] lvl, prv, set, clr, bits, msk;
        int off;
        lvl = m_level();
        prv = m_filt;
        set = (m_rise & lvl & ~prv) | (m_fall & ~lvl & prv) | (m_lvl_en & lvl);
        m_irq = m_ie & (m_pend != 16'h0);
        clr = '0;
        if (enable && write_en && addr < 16'd13) begin
            off  = int'(addr);
            bits = 16'(data_in) << ((off % S) * W);
            msk  = 16'h00FF << ((off % S) * W);
            if (off == 6 * S) m_ie = data_in[0];
            else case (off / S)
                1: m_gpo    = (m_gpo    & ~msk) | bits;
                2: m_rise   = (m_rise   & ~msk) | bits;
                3: m_fall   = (m_fall   & ~msk) | bits;
                4: clr      = bits;
                5: m_lvl_en = (m_lvl_en & ~msk) | bits;
                default: ;
            endcase
        end
        m_pend = (m_pend & ~clr) | set;
        m_filt = lvl;
        for (int k = 4; k > 0; k--) smp[k] = smp[k-1];
        smp[0] = gpi;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock: model follows the edge, then new inputs are applied
    task automatic step(input logic en, input logic [15:0] a, input logic we,
                        input logic [7:0] d, input logic [15:0] g);
        @(posedge clk);
        if (reset) model_step();
        #1;
        enable = en; addr = a; write_en = we; data_in = d; gpi = g;
    endtask

    // Every-cycle comparison against the model
    initial begin
        @(posedge reset);
        forever begin
            @(negedge clk);
            if (done) break;
            chk("data_out", {8'h00, data_out}, {8'h00, m_read(enable, addr)});
            chk("gpo", gpo, m_gpo);
            chk("interrupt", {15'h0, interrupt}, {15'h0, m_irq});
        end
    end

    initial begin
        logic [15:0] g;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_gpo", gpo, 16'h0000);
        chk("rst_irq", {15'h0, interrupt}, 16'h0);
        enable = 1'b1;
        addr = 16'd2;  #1 chk("rst_rd_gpo",  {8'h00, data_out}, 16'h0);
        addr = 16'd8;  #1 chk("rst_rd_pend", {8'h00, data_out}, 16'h0);
        addr = 16'd12; #1 chk("rst_rd_ctrl", {8'h00, data_out}, 16'h0);

        // GPO write/readback
        step(1, 16'd2, 1, 8'hA5, 16'h0);
        step(1, 16'd3, 1, 8'h3C, 16'h0);
        step(1, 16'd2, 0, 8'h00, 16'h0);
        @(negedge clk);
        chk("gpo_lit", gpo, 16'h3CA5);
        chk("rd_gpo_lo", {8'h00, data_out}, 16'h00A5);
        step(1, 16'd3, 0, 8'h00, 16'h0);
        @(negedge clk);
        chk("rd_gpo_hi", {8'h00, data_out}, 16'h003C);
        step(1, 16'd0, 1, 8'hFF, 16'h0);
        step(1, 16'd0, 0, 8'h00, 16'h0);
        @(negedge clk);
        chk("gpi_write_ignored", {8'h00, data_out}, 16'h0000);

        // Rising edge, latency and write-1-to-clear
        step(1, 16'd4, 1, 8'h01, 16'h0);
        step(1, 16'd12, 1, 8'h01, 16'h0);
        step(1, 16'd8, 0, 8'h00, 16'h0001);
        for (int k = 0; k < LAT - 1; k++) begin
            step(1, 16'd8, 0, 8'h00, 16'h0001);
            @(negedge clk);
            chk("rise_pend_early", {8'h00, data_out}, 16'h0000);
        end
        step(1, 16'd8, 0, 8'h00, 16'h0001);
        @(negedge clk);
        chk("rise_pend", {8'h00, data_out}, 16'h0001);
        chk("rise_irq_early", {15'h0, interrupt}, 16'h0);
        step(1, 16'd8, 0, 8'h00, 16'h0001);
        @(negedge clk);
        chk("rise_irq", {15'h0, interrupt}, 16'h1);
        step(1, 16'd8, 1, 8'h01, 16'h0001);
        step(1, 16'd8, 0, 8'h00, 16'h0001);
        @(negedge clk);
        chk("clr_pend", {8'h00, data_out}, 16'h0000);
        chk("clr_irq_lag", {15'h0, interrupt}, 16'h1);
        step(1, 16'd8, 0, 8'h00, 16'h0001);
        @(negedge clk);
        chk("clr_irq", {15'h0, interrupt}, 16'h0);

        // Falling edge on pin 15 with global enable off
        step(1, 16'd4, 1, 8'h00, 16'h0001);
        step(1, 16'd12, 1, 8'h00, 16'h0001);
        step(1, 16'd7, 1, 8'h80, 16'h0001);
        for (int k = 0; k < LAT + 3; k++) step(1, 16'd9, 0, 8'h00, 16'h8001);
        @(negedge clk);
        chk("fall_pend_none", {8'h00, data_out}, 16'h0000);
        for (int k = 0; k < LAT + 2; k++) step(1, 16'd9, 0, 8'h00, 16'h0001);
        @(negedge clk);
        chk("fall_pend", {8'h00, data_out}, 16'h0080);
        chk("fall_irq_off", {15'h0, interrupt}, 16'h0);

        // Level source on pin 1; clear in the same cycle as a set keeps the bit
        step(1, 16'd10, 1, 8'h02, 16'h0001);
        for (int k = 0; k < LAT + 2; k++) step(1, 16'd8, 0, 8'h00, 16'h0003);
        @(negedge clk);
        chk("level_pend", {8'h00, data_out}, 16'h0002);
        step(1, 16'd8, 1, 8'h02, 16'h0003);
        step(1, 16'd8, 0, 8'h00, 16'h0003);
        @(negedge clk);
        chk("level_clr_set", {8'h00, data_out}, 16'h0002);

        // Asynchronous reset discards an in-flight write and clears outputs at once
        step(1, 16'd12, 1, 8'h01, 16'h0003);
        step(1, 16'd2, 1, 8'hFF, 16'h0003);
        step(1, 16'd3, 1, 8'hFF, 16'h0003);
        step(1, 16'd0, 0, 8'h00, 16'h0003);
        step(1, 16'd0, 0, 8'h00, 16'h0003);
        @(negedge clk);
        chk("pre_rst_gpo", gpo, 16'hFFFF);
        chk("pre_rst_irq", {15'h0, interrupt}, 16'h1);
        #1;
        enable = 1'b1; addr = 16'd2; write_en = 1'b1; data_in = 8'h55;
        #1 reset = 1'b0;
        model_reset();
        #1;
        chk("async_rst_gpo", gpo, 16'h0000);
        chk("async_rst_irq", {15'h0, interrupt}, 16'h0);
        @(posedge clk);
        #1 enable = 1'b0; write_en = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_write_lost", gpo, 16'h0000);

`ifdef REFLET_GPIO_IRQ_DEBOUNCE_EN
        // Debounce: short pulse rejected, 6-cycle pulse accepted at edge 6
        step(1, 16'd4, 1, 8'h01, 16'h0);
        for (int k = 0; k < 8; k++) step(1, 16'd8, 0, 8'h00, 16'h0);
        step(1, 16'd8, 0, 8'h00, 16'h0001);
        step(1, 16'd8, 0, 8'h00, 16'h0001);
        for (int k = 0; k < 10; k++) step(1, 16'd8, 0, 8'h00, 16'h0);
        @(negedge clk);
        chk("deb_short", {8'h00, data_out}, 16'h0000);
        for (int k = 0; k < 6; k++) step(1, 16'd8, 0, 8'h00, 16'h0001);
        @(negedge clk);
        chk("deb_long_early", {8'h00, data_out}, 16'h0000);
        step(1, 16'd8, 0, 8'h00, 16'h0);
        @(negedge clk);
        chk("deb_long", {8'h00, data_out}, 16'h0001);
`endif

        // Randomised traffic against the model
        g = gpi;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) g = g ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
            step(($urandom_range(0, 7) != 0), 16'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 8'($urandom), g);
        end

        done = 1'b1;
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
